// File: rtl/run_controller_if.sv
// run_controller_if: handshake and status bundle between the run sequencer and
// the testbench pins and core control decoder.
//   start       : testbench start level (into the controller)
//   done        : decoder done flag (into the controller)
//   run_en      : core execute enable
//   core_clear  : one-cycle clear pulse to PC / register file / scratch state
//   ack         : run finished
//   timeout     : run ended by the watchdog (valid while ack=1)
//   cycle_count : RUN cycles in the current or last run
// Modports: master drives start/done; slave is the controller.
interface run_controller_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             done;
    logic             run_en;
    logic             core_clear;
    logic             ack;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, done,
        input  run_en, core_clear, ack, timeout, cycle_count
    );

    modport slave (
        input  start, done,
        output run_en, core_clear, ack, timeout, cycle_count
    );
endinterface

// File: rtl/run_controller.sv
// run_controller: run sequencer for the single-cycle core.
// Owns the start/ack handshake, gates execution with run_en, pulses core_clear
// once per new run and counts RUN cycles (saturating).
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : run_controller_if.slave (start, done in; run_en, core_clear, ack,
//           timeout, cycle_count out)
// Parameters: MAX_CYCLES (watchdog limit, 1 <= MAX_CYCLES < 2**CNT_W), CNT_W.
// Optional feature: define RUN_CTRL_WATCHDOG_EN to build the watchdog; without
// it timeout stays 0 and RUN exits only on done.
// All outputs are registered; next-state values are computed from the
// transition being taken so each output changes on the same edge as the state.
module run_controller #(
    parameter int MAX_CYCLES = 4096,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          reset,
    run_controller_if.slave bus
);
    // Elaboration-time range check: an illegal MAX_CYCLES instantiates a
    // module that does not exist, so the build stops.
    if (MAX_CYCLES < 1 || 64'(MAX_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_max_cycles
        run_controller_illegal_max_cycles u_bad ();
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             run_en_q, run_en_d;
    logic             clear_q, clear_d;
    logic             ack_q, ack_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             wd_hit;

    // Saturating increment.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

`ifdef RUN_CTRL_WATCHDOG_EN
    // Expiry is seen on the last allowed cycle so the final count is MAX_CYCLES.
    assign wd_hit = (cnt_q == CNT_W'(MAX_CYCLES - 1));
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            run_en_q  <= 1'b0;
            clear_q   <= 1'b0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            run_en_q  <= run_en_d;
            clear_q   <= clear_d;
            ack_q     <= ack_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        run_en_d  = 1'b0;
        clear_d   = 1'b0;
        ack_d     = 1'b0;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = ARMED;
                    clear_d   = 1'b1;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            ARMED: begin
                // clear_d defaults low, so the pulse lasts only the first cycle.
                cnt_d = '0;
                if (!bus.start) begin
                    state_d  = RUN;
                    run_en_d = 1'b1;
                end
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (bus.done) begin
                    // done wins a tie with watchdog expiry
                    state_d   = FINISH;
                    ack_d     = 1'b1;
                    timeout_d = 1'b0;
                end else if (wd_hit) begin
                    state_d   = FINISH;
                    ack_d     = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    run_en_d = 1'b1;
                end
            end
            FINISH: begin
                ack_d = 1'b1;
                if (bus.start) begin
                    state_d   = ARMED;
                    clear_d   = 1'b1;
                    ack_d     = 1'b0;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.run_en      = run_en_q;
    assign bus.core_clear  = clear_q;
    assign bus.ack         = ack_q;
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cnt_q;
endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller. Expected values come from a
// run-level model: a run of length L ends after min(L, MAX) cycles with the
// watchdog, else after L cycles; the count saturates at 2**CNT_W-1.
module tb_run_controller;
    localparam int MAXC = 16;
    localparam int CW   = 6;
    localparam int SAT  = (1 << CW) - 1;
`ifdef RUN_CTRL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   n_run, n_clr;
    bit   ended;
    logic f_ack, f_to, f_clr;
    logic [CW-1:0] f_cnt;

    run_controller_if #(.CNT_W(CW)) bif ();

    run_controller #(.MAX_CYCLES(MAXC), .CNT_W(CW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    always #5 clk = ~clk;

    // Reference model of a completed run of requested length len.
    function automatic int exp_nrun(input int len);
        return (WD && len > MAXC) ? MAXC : len;
    endfunction
    function automatic int exp_cnt(input int len);
        int r;
        r = exp_nrun(len);
        if (r > SAT) r = SAT;
        return r;
    endfunction
    function automatic bit exp_to(input int len);
        return WD && (len > MAXC);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (bif.run_en === 1'b1) n_run++;
        if (bif.core_clear === 1'b1) n_clr++;
    endtask

    // One complete run: start held for hold cycles, done on RUN cycle len.
    // spur adds done during ARMED and random start toggles during RUN.
    task automatic do_run(input int hold, input int len, input bit spur);
        n_run = 0; n_clr = 0; ended = 0;
        bif.start = 1'b1; bif.done = spur;
        step();
        f_ack = bif.ack; f_to = bif.timeout; f_cnt = bif.cycle_count; f_clr = bif.core_clear;
        for (int i = 1; i < hold; i++) step();
        bif.start = 1'b0;
        step();
        for (int c = 1; c <= len + 2 && !ended; c++) begin
            bif.done  = (c == len);
            bif.start = (spur && c < len) ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            if (bif.ack === 1'b1) ended = 1;
        end
        bif.done = 1'b0; bif.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; bif.start = 1'b0; bif.done = 1'b0;
        step(); step();
        total++; if (bif.run_en !== 1'b0) begin bad++; $display("FAIL reset_run_en got=%b want=0", bif.run_en); end
        total++; if (bif.core_clear !== 1'b0) begin bad++; $display("FAIL reset_clear got=%b want=0", bif.core_clear); end
        total++; if (bif.ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", bif.ack); end
        total++; if (bif.timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", bif.timeout); end
        total++; if (bif.cycle_count !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", bif.cycle_count); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        do_run(3, 10, 1'b0);
        total++; if (bif.ack !== 1'b1) begin bad++; $display("FAIL basic_ack got=%b want=1", bif.ack); end
        total++; if (bif.cycle_count !== CW'(10)) begin bad++; $display("FAIL basic_count got=%0d want=10", bif.cycle_count); end
        total++; if (bif.timeout !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%b want=0", bif.timeout); end
        total++; if (n_clr != 1) begin bad++; $display("FAIL basic_clear_pulses got=%0d want=1", n_clr); end
        total++; if (n_run != 10) begin bad++; $display("FAIL basic_run_cycles got=%0d want=10", n_run); end
        step(); step();
        total++; if (bif.ack !== 1'b1 || bif.cycle_count !== CW'(10)) begin bad++; $display("FAIL basic_finish_hold got=%b/%0d want=1/10", bif.ack, bif.cycle_count); end
    endtask

    // Never asserts done within the watchdog window; without the watchdog the
    // run goes long enough to saturate the counter.
    task automatic test_watchdog();
        int len;
        len = 70;
        do_run(2, len, 1'b0);
        total++; if (bif.ack !== 1'b1) begin bad++; $display("FAIL wd_ack got=%b want=1", bif.ack); end
        total++; if (bif.timeout !== exp_to(len)) begin bad++; $display("FAIL wd_timeout got=%b want=%0d", bif.timeout, exp_to(len)); end
        total++; if (bif.cycle_count !== CW'(exp_cnt(len))) begin bad++; $display("FAIL wd_count got=%0d want=%0d", bif.cycle_count, exp_cnt(len)); end
        total++; if (n_run != exp_nrun(len)) begin bad++; $display("FAIL wd_run_cycles got=%0d want=%0d", n_run, exp_nrun(len)); end
        total++; if (bif.run_en !== 1'b0) begin bad++; $display("FAIL wd_run_en got=%b want=0", bif.run_en); end
    endtask

    task automatic test_tie();
        do_run(1, MAXC, 1'b0);
        total++; if (bif.ack !== 1'b1) begin bad++; $display("FAIL tie_ack got=%b want=1", bif.ack); end
        total++; if (bif.timeout !== 1'b0) begin bad++; $display("FAIL tie_timeout got=%b want=0", bif.timeout); end
        total++; if (bif.cycle_count !== CW'(MAXC)) begin bad++; $display("FAIL tie_count got=%0d want=%0d", bif.cycle_count, MAXC); end
    endtask

    task automatic test_spurious();
        reset = 1'b1; step(); reset = 1'b0;
        n_run = 0; n_clr = 0;
        bif.done = 1'b1;
        step(); step(); step();
        bif.done = 1'b0;
        total++; if (bif.ack !== 1'b0 || n_run != 0 || n_clr != 0) begin bad++; $display("FAIL spur_idle got=ack%b run%0d clr%0d want=0/0/0", bif.ack, n_run, n_clr); end
        do_run(3, 7, 1'b1);
        total++; if (bif.ack !== 1'b1 || bif.cycle_count !== CW'(7)) begin bad++; $display("FAIL spur_run got=ack%b cnt%0d want=1/7", bif.ack, bif.cycle_count); end
        total++; if (n_clr != 1 || n_run != 7) begin bad++; $display("FAIL spur_pulses got=clr%0d run%0d want=1/7", n_clr, n_run); end
    endtask

    task automatic test_reset_mid_run();
        n_run = 0; n_clr = 0;
        bif.start = 1'b1; step();
        bif.start = 1'b0; step();
        for (int i = 0; i < 5; i++) step();
        total++; if (bif.cycle_count !== CW'(5) || bif.run_en !== 1'b1) begin bad++; $display("FAIL midrst_pre got=cnt%0d run%b want=5/1", bif.cycle_count, bif.run_en); end
        reset = 1'b1; step(); reset = 1'b0;
        total++; if ({bif.run_en, bif.core_clear, bif.ack, bif.timeout} !== 4'b0 || bif.cycle_count !== '0)
            begin bad++; $display("FAIL midrst_outputs got=%b cnt%0d want=0000/0", {bif.run_en, bif.core_clear, bif.ack, bif.timeout}, bif.cycle_count); end
        n_run = 0; n_clr = 0;
        step(); step(); step();
        total++; if (n_run != 0 || n_clr != 0 || bif.ack !== 1'b0) begin bad++; $display("FAIL midrst_idle got=run%0d clr%0d ack%b want=0/0/0", n_run, n_clr, bif.ack); end
        do_run(2, 6, 1'b0);
        total++; if (bif.ack !== 1'b1 || bif.cycle_count !== CW'(6) || n_clr != 1) begin bad++; $display("FAIL midrst_rerun got=ack%b cnt%0d clr%0d want=1/6/1", bif.ack, bif.cycle_count, n_clr); end
    endtask

    task automatic test_back_to_back();
        do_run(1, 40, 1'b0);
        total++; if (bif.timeout !== exp_to(40)) begin bad++; $display("FAIL b2b_first_timeout got=%b want=%0d", bif.timeout, exp_to(40)); end
        do_run(2, 4, 1'b0);
        total++; if (f_ack !== 1'b0 || f_to !== 1'b0) begin bad++; $display("FAIL b2b_clear_flags got=ack%b to%b want=0/0", f_ack, f_to); end
        total++; if (f_cnt !== '0 || f_clr !== 1'b1) begin bad++; $display("FAIL b2b_rearm got=cnt%0d clr%b want=0/1", f_cnt, f_clr); end
        total++; if (n_clr != 1) begin bad++; $display("FAIL b2b_clear_pulses got=%0d want=1", n_clr); end
        total++; if (bif.cycle_count !== CW'(4) || bif.ack !== 1'b1) begin bad++; $display("FAIL b2b_second got=cnt%0d ack%b want=4/1", bif.cycle_count, bif.ack); end
    endtask

    task automatic test_random();
        int hold, len;
        bit spur;
        for (int it = 0; it < 12; it++) begin
            hold = $urandom_range(1, 4);
            len  = $urandom_range(1, 30);
            spur = 1'($urandom_range(0, 1));
            do_run(hold, len, spur);
            total++;
            if (bif.ack !== 1'b1 || bif.cycle_count !== CW'(exp_cnt(len)) || bif.timeout !== exp_to(len)
                || n_run != exp_nrun(len) || n_clr != 1) begin
                bad++;
                $display("FAIL rand_run%0d len=%0d got=ack%b cnt%0d to%b run%0d clr%0d want=1/%0d/%0d/%0d/1",
                         it, len, bif.ack, bif.cycle_count, bif.timeout, n_run, n_clr,
                         exp_cnt(len), exp_to(len), exp_nrun(len));
            end
        end
    endtask

    initial begin
        bif.start = 1'b0;
        bif.done  = 1'b0;
        test_reset();
        test_basic();
        test_watchdog();
        test_tie();
        test_spurious();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/run_controller.md
# run_controller

Run sequencer for the single-cycle core: it owns the testbench `start`/`ack` handshake and gates execution through `run_en`. It issues a one-cycle clear pulse to the program counter and register file on each new run, and counts executed cycles. An optional watchdog terminates runaway programs. It sits between the top-level handshake pins and the core's control decoder, which consumes `run_en` (instruction forced to NOP when low) and returns `done`.

## Interface
- `MAX_CYCLES`, default 4096: watchdog limit in RUN cycles. Must satisfy 1 ≤ MAX_CYCLES < 2**CNT_W.
- `CNT_W`, default 16: width of the cycle counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  testbench start level.
- `done`  in  1  decoder done flag; sampled only in RUN.
- `run_en`  out  1  core execute enable.
- `core_clear`  out  1  one-cycle clear pulse to PC, register file and scratch state.
- `ack`  out  1  run finished, held high in FINISH.
- `timeout`  out  1  run ended by the watchdog; valid while `ack`=1.
- `cycle_count`  out  CNT_W  number of RUN cycles in the current or last run.

## Operation
- All outputs are registered (Moore).
- Reset values: state IDLE, `run_en`=0, `core_clear`=0, `ack`=0, `timeout`=0, `cycle_count`=0.
- IDLE:
  - All outputs low.
  - `start`=1 → ARMED.
- ARMED:
  - `core_clear`=1 in the first ARMED cycle only.
  - `cycle_count` is held at 0; `run_en`=0; `done` is ignored.
  - `start`=0 → RUN.
- RUN:
  - `run_en`=1.
  - `cycle_count` increments every cycle, including the cycle in which `done` is sampled. It saturates at 2**CNT_W−1.
  - `done`=1 → FINISH with `timeout`=0.
  - `start` is ignored.
- Watchdog (macro enabled): in RUN, when `cycle_count`==MAX_CYCLES−1 and `done`=0, go to FINISH with `timeout`=1. The final count is MAX_CYCLES.
- Simultaneous `done`=1 and watchdog expiry: `done` wins and `timeout`=0.
- FINISH:
  - `ack`=1, `run_en`=0; `cycle_count` and `timeout` are frozen.
  - `start`=1 → ARMED. `ack` and `timeout` clear in the same edge; `cycle_count` clears to 0.
- Reset in any state, including mid-RUN: on the next edge, return to IDLE with reset values. Reset has priority over every transition.

## Timing
- `start` rising at edge N: ARMED from N+1, and `core_clear` is high for exactly the N+1 cycle.
- `start` low sampled at edge M: `run_en` high from M+1. The first RUN cycle executes PC 0.
- `done` sampled at edge K: `ack` high from K+1 and `run_en` low from K+1. No instruction executes after the done instruction.
- `start` held high in ARMED: the controller stays in ARMED. `core_clear` does not re-pulse.
- `start` low in IDLE: stays in IDLE indefinitely.
- `start` toggling in RUN has no effect.
- `done` outside RUN has no effect.

## Configuration
- `RUN_CTRL_WATCHDOG_EN` defined: the watchdog exists as specified and `MAX_CYCLES` is honoured.
- Not defined:
  - The watchdog compare logic is removed and `timeout` is tied 0.
  - RUN exits only on `done`.
  - `cycle_count` still counts and saturates.
  - `MAX_CYCLES` is unused.

## Test plan
- Basic run: reset; `start`=1 for 3 cycles, then 0; `done`=1 on the 10th RUN cycle → `ack` rises the next cycle, `cycle_count`=10, `timeout`=0, exactly one `core_clear` pulse, `run_en` high for exactly 10 cycles.
- Watchdog (macro on, MAX_CYCLES=16): run with `done` never asserted → after 16 RUN cycles `ack`=1, `timeout`=1, `cycle_count`=16, `run_en`=0.
- Tie: MAX_CYCLES=16, `done`=1 on the 16th RUN cycle → `ack`=1, `timeout`=0, `cycle_count`=16.
- Spurious inputs: `done`=1 during IDLE and ARMED, and `start` pulses during RUN → no state change; the run completes normally on the real `done`.
- Reset mid-RUN at `cycle_count`=5 → next cycle all outputs 0 and state IDLE; a subsequent start/done sequence gives a correct `ack` and a fresh count.
- Back-to-back runs: from FINISH with `timeout`=1, raise `start` → `ack`=0, `timeout`=0, `cycle_count`=0, one `core_clear` pulse. The second run with `done` after 4 cycles gives `cycle_count`=4.
